// File: rtl/fp_wrapper_pkg.sv
// fp_wrapper_pkg: shared controller state encoding and default timeout.
package fp_wrapper_pkg;
  typedef enum logic [2:0] {IDLE, GET_B, START, WAIT, DRIVE} ctrl_state_t;
  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: 8-bit up-counter bounding how long the controller waits on the FP core.
//   clk, rst (async active-low), clr (sync clear), en (count enable),
//   expired (count has reached TIMEOUT-1).
module wait_timer
  import fp_wrapper_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 8'd1;
  assign expired = count == 8'(TIMEOUT - 1);
endmodule

// File: rtl/fp_wrapper_ctrl.sv
// fp_wrapper_ctrl: sequences operand loads, FP core start, timeout-guarded wait and result handoff.
//   clk, rst (async active-low); inValid/inReady: operand handshake (leA, leB load strobes);
//   fpStart/fpDone: FP core handshake; outValid/outReady/enTri: result handoff;
//   busy: not idle; err: sticky timeout; opCount: results delivered.
module fp_wrapper_ctrl
  import fp_wrapper_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic             fpDone,
  input  logic             outReady,
  output logic             leA,
  output logic             leB,
  output logic             fpStart,
  output logic             enTri,
  output logic             outValid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] opCount
);
  ctrl_state_t state, next;
  logic expired;
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state == START),
    .en(state == WAIT),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      err     <= 1'b0;
      opCount <= '0;
    end else begin
      state <= next;
      if (state == WAIT && !fpDone && expired) err <= 1'b1;
      if (state == DRIVE && outReady) opCount <= opCount + CNT_W'(1);
    end
  // fpDone is tested before expiry so a same-cycle completion is never discarded.
  always_comb begin
    next     = state;
    inReady  = 1'b0;
    leA      = 1'b0;
    leB      = 1'b0;
    fpStart  = 1'b0;
    enTri    = 1'b0;
    outValid = 1'b0;
    busy     = state != IDLE;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        leA     = inValid;
        next    = inValid ? GET_B : IDLE;
      end
      GET_B: begin
        inReady = 1'b1;
        leB     = inValid;
        next    = inValid ? START : GET_B;
      end
      START: begin
        fpStart = 1'b1;
        next    = WAIT;
      end
      WAIT: next = fpDone ? DRIVE : expired ? IDLE : WAIT;
      DRIVE: begin
        enTri    = 1'b1;
        outValid = 1'b1;
        next     = outReady ? IDLE : DRIVE;
      end
      default: next = IDLE;
    endcase
  end
endmodule
